// File: rtl/alu_hs_mc_if.sv
// ---------------------------------------------------------------------------
// alu_hs_mc_if
// Bundles the request and result handshakes of the alu_hs_mc block.
// Member names are written from the ALU's point of view: i_* are driven
// by the requester/consumer side, o_* are driven by the ALU.
//
// Members:
//   i_reqValid / o_reqReady  request handshake
//   i_mode                   1 = arithmetic, 0 = logical
//   i_cmd                    command code
//   i_opValid                bit0 = operand A valid, bit1 = operand B valid
//   i_opA, i_opB, i_cin      operands and carry/borrow in
//   o_resValid / i_resReady  result handshake
//   o_result                 result word
//   o_err .. o_e             status flags
//   o_busy                   multiplier iterating
//
// Modports: master (command sequencer / result collector), slave (the ALU).
// ---------------------------------------------------------------------------
interface alu_hs_mc_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int CMD_WIDTH    = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
);
    logic                    i_reqValid;
    logic                    o_reqReady;
    logic                    i_mode;
    logic [CMD_WIDTH-1:0]    i_cmd;
    logic [1:0]              i_opValid;
    logic [DATA_WIDTH-1:0]   i_opA;
    logic [DATA_WIDTH-1:0]   i_opB;
    logic                    i_cin;
    logic                    o_resValid;
    logic                    i_resReady;
    logic [RESULT_WIDTH-1:0] o_result;
    logic                    o_err;
    logic                    o_oflow;
    logic                    o_cout;
    logic                    o_g;
    logic                    o_l;
    logic                    o_e;
    logic                    o_busy;

    modport master (
        output i_reqValid, i_mode, i_cmd, i_opValid, i_opA, i_opB, i_cin, i_resReady,
        input  o_reqReady, o_resValid, o_result, o_err, o_oflow, o_cout, o_g, o_l, o_e, o_busy
    );

    modport slave (
        input  i_reqValid, i_mode, i_cmd, i_opValid, i_opA, i_opB, i_cin, i_resReady,
        output o_reqReady, o_resValid, o_result, o_err, o_oflow, o_cout, o_g, o_l, o_e, o_busy
    );
endinterface

// File: rtl/alu_hs_mc.sv
// ---------------------------------------------------------------------------
// alu_hs_mc
// Handshaked ALU holding one transaction in flight. Arithmetic and logical
// commands complete with a registered result one cycle after accept; the two
// multiply commands run an iterative shift-add loop of DATA_WIDTH+1 steps.
// DATA_WIDTH is expected to be a power of two and at least 4.
//
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset, honoured regardless of i_ce
//   i_ce     clock enable; when low every register holds
//   bus      alu_hs_mc_if slave modport (request, result, flags, busy)
// ---------------------------------------------------------------------------
module alu_hs_mc #(
    parameter int DATA_WIDTH   = 8,
    parameter int CMD_WIDTH    = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
    parameter int RA_W         = $clog2(DATA_WIDTH)
) (
    input logic        i_clk,
    input logic        i_reset,
    input logic        i_ce,
    alu_hs_mc_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int RW = RESULT_WIDTH;
    localparam int MW = DATA_WIDTH + 1;
    localparam int PW = 2 * MW;
    localparam int CW = $clog2(MW);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH);

    localparam logic [CMD_WIDTH-1:0]
        A_ADD = CMD_WIDTH'(0),  A_SUB = CMD_WIDTH'(1),  A_ADD_CIN = CMD_WIDTH'(2),
        A_SUB_CIN = CMD_WIDTH'(3), A_INC_A = CMD_WIDTH'(4), A_DEC_A = CMD_WIDTH'(5),
        A_INC_B = CMD_WIDTH'(6), A_DEC_B = CMD_WIDTH'(7), A_CMP = CMD_WIDTH'(8),
        A_MUL_INC = CMD_WIDTH'(9), A_MUL_SHL = CMD_WIDTH'(10),
        A_ADD_S = CMD_WIDTH'(11), A_SUB_S = CMD_WIDTH'(12);

    localparam logic [CMD_WIDTH-1:0]
        L_AND = CMD_WIDTH'(0), L_NAND = CMD_WIDTH'(1), L_OR = CMD_WIDTH'(2),
        L_NOR = CMD_WIDTH'(3), L_XOR = CMD_WIDTH'(4), L_XNOR = CMD_WIDTH'(5),
        L_NOT_A = CMD_WIDTH'(6), L_NOT_B = CMD_WIDTH'(7), L_SHR1_A = CMD_WIDTH'(8),
        L_SHL1_A = CMD_WIDTH'(9), L_SHR1_B = CMD_WIDTH'(10), L_SHL1_B = CMD_WIDTH'(11),
        L_ROL = CMD_WIDTH'(12), L_ROR = CMD_WIDTH'(13);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_mcand;
    logic [MW-1:0]   r_mplier;
    logic [PW-1:0]   r_prod;
    logic [PW-1:0]   w_prodNext;
    logic [RW-1:0]   r_result;
    logic            r_resValid;
    logic            r_err, r_oflow, r_cout, r_g, r_l, r_e;

    logic            w_reqReady;
    logic            w_accept;
    logic [DW-1:0]   w_a, w_b;
    logic [MW-1:0]   w_aExt, w_bExt;
    logic [MW-1:0]   w_add, w_addCin, w_sub, w_subCin, w_bCin;
    logic [MW-1:0]   w_incA, w_decA, w_incB, w_decB;
    logic [MW-1:0]   w_sAdd, w_sSub;
    logic            w_sGt, w_sLt, w_uGt, w_uLt, w_eq;
    logic [RA_W-1:0] w_amt;
    logic [DW-RA_W-1:0] w_rotHigh;
    logic [DW-1:0]   w_rol, w_ror;

    logic [RW-1:0]   w_result;
    logic [DW-1:0]   w_logic;
    logic            w_err, w_oflow, w_cout, w_g, w_l, w_e;
    logic            w_needA, w_needB, w_known, w_isMul;
    logic [PW-1:0]   w_mcandInit;
    logic [MW-1:0]   w_mplierInit;

    // The block is ready when idle, or when it is holding a result that the
    // consumer is taking this very cycle; the latter gives back-to-back
    // throughput of one single-cycle command per clock.
    assign w_reqReady = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.i_resReady);
    assign w_accept   = bus.i_reqValid && w_reqReady && i_ce;

    // Shared arithmetic terms, all computed one bit wider than the operands
    // so that carries and borrows land in bit DATA_WIDTH.
    assign w_a       = bus.i_opA;
    assign w_b       = bus.i_opB;
    assign w_aExt    = {1'b0, w_a};
    assign w_bExt    = {1'b0, w_b};
    assign w_add     = w_aExt + w_bExt;
    assign w_addCin  = w_aExt + w_bExt + MW'(bus.i_cin);
    assign w_sub     = w_aExt - w_bExt;
    assign w_bCin    = w_bExt + MW'(bus.i_cin);
    assign w_subCin  = w_aExt - w_bCin;
    assign w_incA    = w_aExt + MW'(1);
    assign w_decA    = w_aExt - MW'(1);
    assign w_incB    = w_bExt + MW'(1);
    assign w_decB    = w_bExt - MW'(1);
    assign w_sAdd    = {w_a[DW-1], w_a} + {w_b[DW-1], w_b};
    assign w_sSub    = {w_a[DW-1], w_a} - {w_b[DW-1], w_b};
    assign w_sGt     = $signed(w_a) > $signed(w_b);
    assign w_sLt     = $signed(w_a) < $signed(w_b);
    assign w_uGt     = w_a > w_b;
    assign w_uLt     = w_a < w_b;
    assign w_eq      = w_a == w_b;

    // A shift by the full width yields zero, so an amount of 0 returns A.
    assign w_amt     = w_b[RA_W-1:0];
    assign w_rotHigh = w_b[DW-1:RA_W];
    assign w_rol     = (w_a << w_amt) | (w_a >> (DW - int'(w_amt)));
    assign w_ror     = (w_a >> w_amt) | (w_a << (DW - int'(w_amt)));

    // Decode the presented request into the result and flags that will be
    // registered on accept. Operand-valid and unknown-command checks run
    // last and override everything with a bare ERR.
    always_comb begin
        w_result     = '0;
        w_logic      = '0;
        w_err        = 1'b0;
        w_oflow      = 1'b0;
        w_cout       = 1'b0;
        w_g          = 1'b0;
        w_l          = 1'b0;
        w_e          = 1'b0;
        w_needA      = 1'b1;
        w_needB      = 1'b1;
        w_known      = 1'b1;
        w_isMul      = 1'b0;
        w_mcandInit  = '0;
        w_mplierInit = '0;
        if (bus.i_mode) begin
            case (bus.i_cmd)
                A_ADD:     begin w_result = RW'(w_add);    w_cout = w_add[DW];    end
                A_SUB:     begin w_result = RW'(w_sub);    w_oflow = w_uLt;       end
                A_ADD_CIN: begin w_result = RW'(w_addCin); w_cout = w_addCin[DW]; end
                A_SUB_CIN: begin w_result = RW'(w_subCin); w_oflow = (w_aExt < w_bCin); end
                A_INC_A:   begin w_needB = 1'b0; w_result = RW'(w_incA); w_oflow = &w_a;        end
                A_DEC_A:   begin w_needB = 1'b0; w_result = RW'(w_decA); w_oflow = (w_a == '0); end
                A_INC_B:   begin w_needA = 1'b0; w_result = RW'(w_incB); w_oflow = &w_b;        end
                A_DEC_B:   begin w_needA = 1'b0; w_result = RW'(w_decB); w_oflow = (w_b == '0); end
                A_CMP:     begin w_g = w_uGt; w_l = w_uLt; w_e = w_eq; end
                A_MUL_INC: begin
                    w_isMul      = 1'b1;
                    w_mcandInit  = PW'(w_incA);
                    w_mplierInit = w_incB;
                end
                A_MUL_SHL: begin
                    w_isMul      = 1'b1;
                    w_mcandInit  = PW'({w_a, 1'b0});
                    w_mplierInit = w_bExt;
                end
                A_ADD_S: begin
                    w_result = {{(RW-MW){w_sAdd[DW]}}, w_sAdd};
                    w_oflow  = (w_a[DW-1] == w_b[DW-1]) && (w_sAdd[DW-1] != w_a[DW-1]);
                    w_g = w_sGt; w_l = w_sLt; w_e = w_eq;
                end
                A_SUB_S: begin
                    w_result = {{(RW-MW){w_sSub[DW]}}, w_sSub};
                    w_oflow  = (w_a[DW-1] != w_b[DW-1]) && (w_sSub[DW-1] != w_a[DW-1]);
                    w_g = w_sGt; w_l = w_sLt; w_e = w_eq;
                end
                default:   w_known = 1'b0;
            endcase
        end else begin
            case (bus.i_cmd)
                L_AND:    w_logic = w_a & w_b;
                L_NAND:   w_logic = ~(w_a & w_b);
                L_OR:     w_logic = w_a | w_b;
                L_NOR:    w_logic = ~(w_a | w_b);
                L_XOR:    w_logic = w_a ^ w_b;
                L_XNOR:   w_logic = ~(w_a ^ w_b);
                L_NOT_A:  begin w_needB = 1'b0; w_logic = ~w_a;      end
                L_NOT_B:  begin w_needA = 1'b0; w_logic = ~w_b;      end
                L_SHR1_A: begin w_needB = 1'b0; w_logic = w_a >> 1;  end
                L_SHL1_A: begin w_needB = 1'b0; w_logic = w_a << 1;  end
                L_SHR1_B: begin w_needA = 1'b0; w_logic = w_b >> 1;  end
                L_SHL1_B: begin w_needA = 1'b0; w_logic = w_b << 1;  end
                L_ROL:    begin w_logic = w_rol; w_err = |w_rotHigh; end
                L_ROR:    begin w_logic = w_ror; w_err = |w_rotHigh; end
                default:  w_known = 1'b0;
            endcase
            w_result = RW'(w_logic);
        end
        if (!w_known || (bus.i_opValid == 2'b00) ||
            (w_needA && !bus.i_opValid[0]) || (w_needB && !bus.i_opValid[1])) begin
            w_result = '0;
            w_err    = 1'b1;
            w_oflow  = 1'b0;
            w_cout   = 1'b0;
            w_g      = 1'b0;
            w_l      = 1'b0;
            w_e      = 1'b0;
            w_isMul  = 1'b0;
        end
    end

    // Next-state logic. IDLE and DONE share the accept path; DONE falls back
    // to IDLE only when the result is consumed without a new request.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_stateNext = w_isMul ? S_MUL : S_DONE;
                else if ((r_state == S_DONE) && bus.i_resReady)
                    w_stateNext = S_IDLE;
            end
            S_MUL: begin
                if (r_count == LAST_ITER)
                    w_stateNext = S_DONE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // State register; reset wins over the clock enable.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else if (i_ce)
            r_state <= w_stateNext;
    end

    assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);

    // Datapath registers. A single-cycle command registers its result on
    // accept. A multiply loads the shift-add operands on accept, then each
    // MUL cycle adds one partial product; the final step writes the result
    // directly from the adder so RES_VALID appears as the loop finishes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count    <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_result   <= '0;
            r_resValid <= 1'b0;
            r_err      <= 1'b0;
            r_oflow    <= 1'b0;
            r_cout     <= 1'b0;
            r_g        <= 1'b0;
            r_l        <= 1'b0;
            r_e        <= 1'b0;
        end else if (i_ce) begin
            if (w_accept) begin
                if (w_isMul) begin
                    r_count    <= '0;
                    r_mcand    <= w_mcandInit;
                    r_mplier   <= w_mplierInit;
                    r_prod     <= '0;
                    r_resValid <= 1'b0;
                end else begin
                    r_result   <= w_result;
                    r_err      <= w_err;
                    r_oflow    <= w_oflow;
                    r_cout     <= w_cout;
                    r_g        <= w_g;
                    r_l        <= w_l;
                    r_e        <= w_e;
                    r_resValid <= 1'b1;
                end
            end else if (r_state == S_MUL) begin
                r_prod   <= w_prodNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
                if (r_count == LAST_ITER) begin
                    r_result   <= w_prodNext[RW-1:0];
                    r_oflow    <= |w_prodNext[PW-1:RW];
                    r_err      <= 1'b0;
                    r_cout     <= 1'b0;
                    r_g        <= 1'b0;
                    r_l        <= 1'b0;
                    r_e        <= 1'b0;
                    r_resValid <= 1'b1;
                end
            end else if ((r_state == S_DONE) && bus.i_resReady) begin
                r_resValid <= 1'b0;
            end
        end
    end

    assign bus.o_reqReady = w_reqReady;
    assign bus.o_resValid = r_resValid;
    assign bus.o_result   = r_result;
    assign bus.o_err      = r_err;
    assign bus.o_oflow    = r_oflow;
    assign bus.o_cout     = r_cout;
    assign bus.o_g        = r_g;
    assign bus.o_l        = r_l;
    assign bus.o_e        = r_e;
    assign bus.o_busy     = (r_state == S_MUL);
endmodule

// File: tb/tb_alu_hs_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_hs_mc
// Directed self-checking bench for alu_hs_mc (DATA_WIDTH=8). Each vector
// carries a hand-computed result and a flag word ordered
// {err, oflow, cout, g, l, e}.
// ---------------------------------------------------------------------------
module tb_alu_hs_mc;
    localparam int DW = 8;
    localparam int CMDW = 4;
    localparam int RW = 16;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   checks = 0;
    int   failures = 0;

    alu_hs_mc_if #(.DATA_WIDTH(DW), .CMD_WIDTH(CMDW), .RESULT_WIDTH(RW)) bus ();

    alu_hs_mc #(.DATA_WIDTH(DW), .CMD_WIDTH(CMDW), .RESULT_WIDTH(RW)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_ce    (ce),
        .bus     (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net so a stuck handshake can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] flagsNow();
        return 32'({bus.o_err, bus.o_oflow, bus.o_cout, bus.o_g, bus.o_l, bus.o_e});
    endfunction

    // Present one request, confirm the block is ready for it, and let one
    // edge accept it. Returns one time unit after the accepting edge.
    task automatic applyStimulus(input string tag, input logic mode, input logic [3:0] cmd,
                                 input logic [1:0] opValid, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
        bus.i_mode     = mode;
        bus.i_cmd      = cmd;
        bus.i_opValid  = opValid;
        bus.i_opA      = a;
        bus.i_opB      = b;
        bus.i_cin      = cin;
        bus.i_reqValid = 1'b1;
        checkOutput({tag, "_rdy"}, 32'(bus.o_reqReady), 1);
        @(posedge clk);
        #1;
        bus.i_reqValid = 1'b0;
    endtask

    // Wait (bounded) for RES_VALID, counting cycles since accept along with
    // how many of the waiting cycles showed BUSY and REQ_READY.
    task automatic waitResult(input int startCycle, output int cycles,
                              output int busyCnt, output int readyCnt);
        cycles   = startCycle;
        busyCnt  = 0;
        readyCnt = 0;
        while (!bus.o_resValid && cycles < 60) begin
            if (bus.o_busy) busyCnt++;
            if (bus.o_reqReady) readyCnt++;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [15:0] expResult,
                               input logic [5:0] expFlags);
        checkOutput({tag, "_vld"}, 32'(bus.o_resValid), 1);
        checkOutput({tag, "_res"}, 32'(bus.o_result), 32'(expResult));
        checkOutput({tag, "_flg"}, flagsNow(), 32'(expFlags));
    endtask

    // Single-cycle command: accept, expect the result one cycle later.
    task automatic runVector(input string tag, input logic mode, input logic [3:0] cmd,
                             input logic [1:0] opValid, input logic [7:0] a,
                             input logic [7:0] b, input logic cin,
                             input logic [15:0] expResult, input logic [5:0] expFlags);
        int cyc, bsy, rdy;
        applyStimulus(tag, mode, cmd, opValid, a, b, cin);
        waitResult(1, cyc, bsy, rdy);
        checkOutput({tag, "_lat"}, cyc, 1);
        checkResult(tag, expResult, expFlags);
    endtask

    initial begin
        int cyc, bsy, rdy, seen;
        reset          = 1'b1;
        ce             = 1'b1;
        bus.i_reqValid = 1'b0;
        bus.i_mode     = 1'b0;
        bus.i_cmd      = 4'd0;
        bus.i_opValid  = 2'b00;
        bus.i_opA      = 8'd0;
        bus.i_opB      = 8'd0;
        bus.i_cin      = 1'b0;
        bus.i_resReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(bus.o_reqReady), 1);
        checkOutput("rst_valid", 32'(bus.o_resValid), 0);
        checkOutput("rst_result", 32'(bus.o_result), 0);
        checkOutput("rst_flags", flagsNow(), 0);
        checkOutput("rst_busy", 32'(bus.o_busy), 0);

        $display("[TB] add with carry out");
        runVector("add", 1'b1, 4'd0, 2'b11, 8'd200, 8'd100, 1'b0, 16'h012C, 6'b001000);

        $display("[TB] multiplies");
        applyStimulus("mulinc", 1'b1, 4'd9, 2'b11, 8'd255, 8'd255, 1'b0);
        waitResult(1, cyc, bsy, rdy);
        checkOutput("mulinc_lat", cyc, 10);
        checkOutput("mulinc_busy", bsy, 9);
        checkOutput("mulinc_rdy0", rdy, 0);
        checkResult("mulinc", 16'h0000, 6'b010000);
        applyStimulus("mulshl", 1'b1, 4'd10, 2'b11, 8'd200, 8'd3, 1'b0);
        waitResult(1, cyc, bsy, rdy);
        checkOutput("mulshl_lat", cyc, 10);
        checkResult("mulshl", 16'h04B0, 6'b000000);

        $display("[TB] result back-pressure then back-to-back");
        applyStimulus("sub", 1'b1, 4'd1, 2'b11, 8'd5, 8'd9, 1'b0);
        bus.i_resReady = 1'b0;
        waitResult(1, cyc, bsy, rdy);
        checkOutput("sub_lat", cyc, 1);
        checkResult("sub", 16'h01FC, 6'b010000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkResult("sub_hold", 16'h01FC, 6'b010000);
            checkOutput("sub_hold_rdy", 32'(bus.o_reqReady), 0);
        end
        bus.i_resReady = 1'b1;
        #1;
        checkOutput("sub_release_rdy", 32'(bus.o_reqReady), 1);
        runVector("xor1", 1'b0, 4'd4, 2'b11, 8'hF0, 8'h3C, 1'b0, 16'h00CC, 6'b000000);
        runVector("xor2", 1'b0, 4'd4, 2'b11, 8'hAA, 8'h0F, 1'b0, 16'h00A5, 6'b000000);

        $display("[TB] rotates and operand errors");
        runVector("rol", 1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0, 16'h0003, 6'b100000);
        runVector("ror", 1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0, 16'h00C0, 6'b000000);
        runVector("inca_bad", 1'b1, 4'd4, 2'b10, 8'h33, 8'h00, 1'b0, 16'h0000, 6'b100000);
        runVector("opv00", 1'b0, 4'd0, 2'b00, 8'hFF, 8'hFF, 1'b0, 16'h0000, 6'b100000);
        runVector("badcmd", 1'b1, 4'd15, 2'b11, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b100000);

        $display("[TB] signed ops and compares");
        runVector("adds", 1'b1, 4'd11, 2'b11, 8'h7F, 8'h01, 1'b0, 16'h0080, 6'b010100);
        runVector("subs", 1'b1, 4'd12, 2'b11, 8'h80, 8'h01, 1'b0, 16'hFF7F, 6'b010010);
        runVector("cmp_eq", 1'b1, 4'd8, 2'b11, 8'd7, 8'd7, 1'b0, 16'h0000, 6'b000001);
        runVector("cmp_lt", 1'b1, 4'd8, 2'b11, 8'd3, 8'd9, 1'b0, 16'h0000, 6'b000010);

        $display("[TB] remaining single-cycle commands");
        runVector("addcin", 1'b1, 4'd2, 2'b11, 8'h80, 8'h7F, 1'b1, 16'h0100, 6'b001000);
        runVector("subcin", 1'b1, 4'd3, 2'b11, 8'd10, 8'd3, 1'b1, 16'h0006, 6'b000000);
        runVector("deca", 1'b1, 4'd5, 2'b01, 8'h10, 8'hFF, 1'b0, 16'h000F, 6'b000000);
        runVector("incb", 1'b1, 4'd6, 2'b10, 8'h00, 8'h41, 1'b0, 16'h0042, 6'b000000);
        runVector("nand", 1'b0, 4'd1, 2'b11, 8'hF0, 8'h3C, 1'b0, 16'h00CF, 6'b000000);
        runVector("shl1a", 1'b0, 4'd9, 2'b01, 8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000);

        $display("[TB] clock enable stall mid-multiply");
        applyStimulus("mulce", 1'b1, 4'd9, 2'b11, 8'd2, 8'd3, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("mulce_frz_busy", 32'(bus.o_busy), 1);
            checkOutput("mulce_frz_vld", 32'(bus.o_resValid), 0);
        end
        ce = 1'b1;
        waitResult(6, cyc, bsy, rdy);
        checkOutput("mulce_lat", cyc, 13);
        checkOutput("mulce_busy", bsy, 7);
        checkResult("mulce", 16'h000C, 6'b000000);

        $display("[TB] reset mid-multiply");
        applyStimulus("mulrst", 1'b1, 4'd9, 2'b11, 8'd255, 8'd255, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mulrst_vld", 32'(bus.o_resValid), 0);
        checkOutput("mulrst_busy", 32'(bus.o_busy), 0);
        checkOutput("mulrst_rdy", 32'(bus.o_reqReady), 1);
        checkOutput("mulrst_res", 32'(bus.o_result), 0);
        checkOutput("mulrst_flg", flagsNow(), 0);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.o_resValid) seen++;
        end
        checkOutput("mulrst_novld", seen, 0);
        runVector("post_rst", 1'b1, 4'd0, 2'b11, 8'd3, 8'd4, 1'b0, 16'h0007, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
